// File: rtl/in_hand_shaking_if.sv
// Link-side handshake bundle for the input handshake stage.
// The master drives si/in_packet/full; the slave returns ri and the FIFO write side.
interface in_hand_shaking_if #(
    parameter int PKT_W = 64,
    parameter int CNT_W = 16
);
    logic             si;
    logic [PKT_W-1:0] in_packet;
    logic             ri;
    logic             full;
    logic             write_en;
    logic [PKT_W-1:0] out_packet;
    logic [CNT_W-1:0] pkt_count;
    logic             cnt_sat;

    modport master (
        output si, in_packet, full,
        input  ri, write_en, out_packet, pkt_count, cnt_sat
    );

    modport slave (
        input  si, in_packet, full,
        output ri, write_en, out_packet, pkt_count, cnt_sat
    );
endinterface

// File: rtl/in_hand_shaking.sv
// Receive-side si/ri handshake with a 2-entry skid buffer feeding the input FIFO.
// Also keeps a saturating count of accepted packets.
module in_hand_shaking #(
    parameter int PKT_W = 64,
    parameter int CNT_W = 16
) (
    input logic              clk,
    input logic              reset,
    in_hand_shaking_if.slave bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    occ_e             state;
    occ_e             state_nx;
    logic [PKT_W-1:0] entry0;
    logic [PKT_W-1:0] entry1;
    logic [PKT_W-1:0] entry0_nx;
    logic [PKT_W-1:0] entry1_nx;
    logic [CNT_W-1:0] cnt_q;
    logic             acc;
    logic             drn;

    assign acc = bus.si && bus.ri;
    assign drn = bus.write_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= EMPTY;
            entry0 <= '0;
            entry1 <= '0;
        end else begin
            state  <= state_nx;
            entry0 <= entry0_nx;
            entry1 <= entry1_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        entry0_nx = entry0;
        entry1_nx = entry1;
        unique case (state)
            EMPTY: begin
                if (acc) begin
                    state_nx  = ONE;
                    entry0_nx = bus.in_packet;
                end
            end
            ONE: begin
                if (acc && !drn) begin
                    state_nx  = TWO;
                    entry1_nx = bus.in_packet;
                end else if (!acc && drn) begin
                    state_nx = EMPTY;
                end else if (acc && drn) begin
                    entry0_nx = bus.in_packet;
                end
            end
            TWO: begin
                if (drn) begin
                    state_nx  = ONE;
                    entry0_nx = entry1;
                end
            end
            default: state_nx = EMPTY;
        endcase
    end

    // ri looks only at occupancy so upstream's si cannot loop back into it
    always_comb begin
        bus.ri         = !reset && (state != TWO);
        bus.write_en   = (state != EMPTY) && !bus.full;
        bus.out_packet = entry0;
        bus.pkt_count  = cnt_q;
        bus.cnt_sat    = &cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (acc && !(&cnt_q)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_in_hand_shaking.sv
// Bench for in_hand_shaking: directed scenarios plus random traffic,
// checked against a queue-based model of the skid buffer and counter.
module tb_in_hand_shaking;

    logic clk;
    logic reset;

    in_hand_shaking_if #(.PKT_W(64), .CNT_W(16)) bus ();
    in_hand_shaking_if #(.PKT_W(64), .CNT_W(4))  sbus ();

    in_hand_shaking #(.PKT_W(64), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    in_hand_shaking #(.PKT_W(64), .CNT_W(4)) dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (sbus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          errors = 0;
    int          checks = 0;
    logic [63:0] q[$];
    logic [63:0] last_out = '0;
    int unsigned n_acc = 0;
    bit          last_acc = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_ri();
        return !reset && (q.size() < 2);
    endfunction

    task automatic check_all();
        logic        e_we;
        logic [63:0] e_out;
        int unsigned c16;
        int unsigned c4;
        e_we  = (q.size() > 0) && !bus.full;
        e_out = (q.size() > 0) ? q[0] : last_out;
        c16   = (n_acc > 65535) ? 65535 : n_acc;
        c4    = (n_acc > 15) ? 15 : n_acc;
        chk("ri", 64'(bus.ri), 64'(exp_ri()));
        chk("write_en", 64'(bus.write_en), 64'(e_we));
        chk("out_packet", bus.out_packet, e_out);
        chk("pkt_count", 64'(bus.pkt_count), 64'(c16));
        chk("cnt_sat", 64'(bus.cnt_sat), 64'(n_acc >= 65535));
        chk("s_ri", 64'(sbus.ri), 64'(exp_ri()));
        chk("s_out_packet", sbus.out_packet, e_out);
        chk("s_pkt_count", 64'(sbus.pkt_count), 64'(c4));
        chk("s_cnt_sat", 64'(sbus.cnt_sat), 64'(n_acc >= 15));
    endtask

    task automatic model_clear();
        q.delete();
        last_out = '0;
        n_acc    = 0;
        last_acc = 0;
    endtask

    task automatic drive(input logic s, input logic [63:0] p,
                         input logic f);
        bus.si         = s;
        bus.in_packet  = p;
        bus.full       = f;
        sbus.si        = s;
        sbus.in_packet = p;
        sbus.full      = f;
    endtask

    // One clock: check before the edge, then advance the model by the edge's events
    task automatic step(input logic s, input logic [63:0] p,
                        input logic f);
        bit a;
        bit d;
        drive(s, p, f);
        @(negedge clk);
        check_all();
        a = s && exp_ri();
        d = (q.size() > 0) && !f;
        @(posedge clk);
        if (d) last_out = q.pop_front();
        if (a) begin
            q.push_back(p);
            n_acc++;
        end
        last_acc = a;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_clear();
        #1;
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic        hs;
        logic [63:0] hp;
        reset = 1'b1;
        drive(1'b0, '0, 1'b0);
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // single packet latency
        step(1'b1, 64'hA5A5_0000_0000_0001, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);

        // back-to-back stream
        for (int i = 1; i <= 8; i++) step(1'b1, 64'(i), 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);

        // fill while full, then release
        step(1'b1, 64'h10, 1'b1);
        step(1'b1, 64'h11, 1'b1);
        step(1'b1, 64'h12, 1'b1);
        step(1'b1, 64'h12, 1'b1);
        step(1'b1, 64'h12, 1'b0);
        step(1'b1, 64'h12, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);

        // simultaneous accept and drain in ONE
        step(1'b1, 64'h20, 1'b1);
        step(1'b1, 64'h21, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);

        // async reset while holding two packets
        step(1'b1, 64'h40, 1'b1);
        step(1'b1, 64'h41, 1'b1);
        drive(1'b0, '0, 1'b1);
        @(negedge clk);
        check_all();
        #2;
        reset = 1'b1;
        model_clear();
        #1;
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b1, 64'h30, 1'b0);
        step(1'b1, 64'h31, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);

        // saturating counter on the 4-bit instance
        do_reset();
        for (int i = 1; i <= 17; i++) step(1'b1, 64'(i + 'h100), 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);

        // random traffic; upstream holds a refused packet
        do_reset();
        hs = 1'b0;
        hp = '0;
        for (int i = 0; i < 400; i++) begin
            if (!(hs && !last_acc) || i == 0) begin
                hs = ($urandom_range(0, 99) < 70);
                hp = {$urandom, $urandom};
            end
            step(hs, hp, ($urandom_range(0, 99) < 40));
        end
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/in_hand_shaking.md
Name: in_hand_shaking

Overview:
- Receive-side counterpart of the router output handshake stage.
- Accepts 64-bit packets from an upstream link using the si/ri (send-in / ready-in) protocol and buffers them in a 2-entry skid buffer.
- Writes them into the local input FIFO using write_en/full.
- Sits between a link's incoming wires and an input-port FIFO of a NoC router, and keeps a saturating count of accepted packets.

Parameters:
- PKT_W, 64, packet width in bits.
- CNT_W, 16, width of the accepted-packet counter.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- si  input  1  upstream asserts: in_packet valid this cycle
- in_packet  input  PKT_W  packet from upstream link
- ri  output  1  ready-in to upstream; transfer occurs on a rising edge where si && ri
- full  input  1  local input FIFO full
- write_en  output  1  write strobe to local FIFO; write occurs on a rising edge where write_en is high
- out_packet  output  PKT_W  data to local FIFO, valid when write_en is high
- pkt_count  output  CNT_W  number of packets accepted since reset, saturating
- cnt_sat  output  1  high once pkt_count has reached all-ones

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-high, and affects every register immediately, not waiting for clk.
- Reset values:
  - occupancy=0; entry0=entry1=0
  - ri=0, write_en=0, out_packet=0
  - pkt_count=0, cnt_sat=0
- ri while in reset: ri is forced 0 while reset is high.
- ri decoding (combinational):
  - ri = !reset && (occupancy < 2).
  - ri must not depend combinationally on si. Upstream so is combinational on our ri; a dependency back would form a loop.
- write_en / out_packet decoding (combinational):
  - write_en = (occupancy != 0) && !full.
  - out_packet = entry0 (head) at all times; it holds its last value when the buffer is empty.
- Events per rising edge:
  - acc = si && ri
  - drn = write_en
- Occupancy states:
  - EMPTY (0):
    - acc → ONE, entry0 <= in_packet.
    - drn is impossible in EMPTY.
  - ONE (1):
    - acc && !drn → TWO, entry1 <= in_packet.
    - !acc && drn → EMPTY.
    - acc && drn → stay ONE, entry0 <= in_packet (simultaneous accept and drain).
    - neither → hold.
  - TWO (2):
    - ri=0, so acc is impossible.
    - drn → ONE, entry0 <= entry1.
    - !drn → hold.
- Ordering: strict FIFO; packets leave in acceptance order. No packet is ever dropped or duplicated.
- Latency: a packet accepted at edge N drives out_packet/write_en from edge N onward, so the earliest FIFO write is edge N+1. No combinational in→out bypass.
- Throughput:
  - With full=0, one packet per cycle is sustained: state stays ONE, ri constantly 1.
  - When full=1, the buffer absorbs up to 2 packets, then ri drops.
- si while ri=0: the upstream holds in_packet and si; the block ignores it with no state change.
- full toggling: may toggle any cycle. write_en follows combinationally; no write is issued while full=1.
- Counter:
  - pkt_count increments by 1 on every acc.
  - At all-ones it holds and cnt_sat=1; cnt_sat stays 1 until reset.
- Reset mid-operation: buffered packets are discarded, and all outputs return to reset values asynchronously. The first accept is possible on the first edge after reset deasserts.

Test Plan:
- Reset, then si=1 with in_packet=0xA5A5_0000_0000_0001, full=0 → ri=1; after edge 1, write_en=1 and out_packet=0xA5A5_0000_0000_0001; after edge 2, write_en=0 and pkt_count=1.
- Stream of 8 packets 0x1..0x8 on consecutive cycles with full=0 → ri held 1 throughout; FIFO receives 0x1..0x8 in order, one per cycle; pkt_count=8.
- full=1, si=1 with 0x10, 0x11, 0x12 → 0x10 and 0x11 accepted, ri=0 after 2 accepts, 0x12 held upstream. Release full → writes 0x10, 0x11, 0x12 in order, no loss.
- Occupancy ONE with simultaneous si=1 (0x21) and write_en=1 (head 0x20) → FIFO gets 0x20, next out_packet=0x21, occupancy stays 1, ri stays 1.
- Occupancy TWO, assert reset asynchronously mid-cycle → ri, write_en, out_packet and pkt_count go to 0 immediately, before the next clk edge; after release the first packet accepted is the first written.
- CNT_W=4: accept 17 packets → pkt_count=15 and cnt_sat=1 after the 15th accept; both hold through the 16th and 17th.
